// File: rtl/game_driver.sv
// Autonomous player for the game block: loads a start value, issues counter
// moves by a selectable strategy and tallies WINNER/LOSER events until the game ends.
module game_driver #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned MAX_MOVES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       strategy,
  input  logic [WIDTH-1:0] seed,
  output logic [1:0]       CTRL,
  output logic             INIT,
  output logic [WIDTH-1:0] init_val,
  input  logic             WINNER,
  input  logic             LOSER,
  input  logic             GAMEOVER,
  input  logic [1:0]       WHO,
  output logic             busy,
  output logic             done,
  output logic [1:0]       result,
  output logic             timeout,
  output logic [3:0]       win_events,
  output logic [3:0]       lose_events,
  output logic [7:0]       moves
);

  localparam int unsigned LFSR_W = 8;
  localparam int unsigned SEED_W = (WIDTH > 5) ? WIDTH : 5;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned MOVE_W = 8;

  localparam logic [1:0] UP_1   = 2'b00;
  localparam logic [1:0] UP_2   = 2'b01;
  localparam logic [1:0] DOWN_1 = 2'b10;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

  state_t              state, state_d;
  logic [1:0]          strat, strat_d;
  logic [WIDTH-1:0]    seed_q, seed_d;
  logic [LFSR_W-1:0]   lfsr, lfsr_d;
  logic                alt, alt_d;
  logic                win_prev, win_prev_d;
  logic                lose_prev, lose_prev_d;
  logic [1:0]          ctrl_d;
  logic                init_d;
  logic [WIDTH-1:0]    init_val_d;
  logic                busy_d;
  logic                done_d;
  logic [1:0]          result_d;
  logic                timeout_d;
  logic [CNT_W-1:0]    win_events_d, lose_events_d;
  logic [MOVE_W-1:0]   moves_d, moves_inc;

  // Next-state and next-output logic
  always_comb begin
    state_d       = state;
    strat_d       = strat;
    seed_d        = seed_q;
    lfsr_d        = lfsr;
    alt_d         = alt;
    win_prev_d    = win_prev;
    lose_prev_d   = lose_prev;
    ctrl_d        = UP_1;
    init_d        = 1'b0;
    init_val_d    = init_val;
    done_d        = 1'b0;
    result_d      = result;
    timeout_d     = timeout;
    win_events_d  = win_events;
    lose_events_d = lose_events;
    moves_d       = moves;
    moves_inc     = moves + MOVE_W'(1);

    case (state)
      IDLE: begin
        if (start) begin
          strat_d       = strategy;
          seed_d        = seed;
          result_d      = 2'b00;
          timeout_d     = 1'b0;
          win_events_d  = '0;
          lose_events_d = '0;
          moves_d       = '0;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        init_d      = 1'b1;
        init_val_d  = seed_q;
        lfsr_d      = LFSR_W'({3'b101, SEED_W'(seed_q)});
        win_prev_d  = 1'b0;
        lose_prev_d = 1'b0;
        alt_d       = 1'b0;
        state_d     = PLAY;
      end
      PLAY: begin
        moves_d = moves_inc;
        case (strat)
          2'd0:    ctrl_d = UP_1;
          2'd1:    ctrl_d = DOWN_1;
          2'd2:    ctrl_d = alt ? DOWN_1 : UP_2;
          default: ctrl_d = lfsr[1:0];
        endcase
        lfsr_d      = {lfsr[LFSR_W-2:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        alt_d       = ~alt;
        win_prev_d  = WINNER;
        lose_prev_d = LOSER;
        // Edges coincident with GAMEOVER still count
        if (WINNER && !win_prev && (win_events != 4'hF))
          win_events_d = win_events + CNT_W'(1);
        if (LOSER && !lose_prev && (lose_events != 4'hF))
          lose_events_d = lose_events + CNT_W'(1);
        if (GAMEOVER) begin
          result_d  = WHO;
          timeout_d = 1'b0;
          state_d   = DONE;
        end else if (moves_inc == MOVE_W'(MAX_MOVES)) begin
          result_d  = 2'b00;
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == LOAD) || (state_d == PLAY);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      strat       <= 2'b00;
      seed_q      <= '0;
      lfsr        <= 8'h01;
      alt         <= 1'b0;
      win_prev    <= 1'b0;
      lose_prev   <= 1'b0;
      CTRL        <= 2'b00;
      INIT        <= 1'b0;
      init_val    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= 2'b00;
      timeout     <= 1'b0;
      win_events  <= '0;
      lose_events <= '0;
      moves       <= '0;
    end else begin
      state       <= state_d;
      strat       <= strat_d;
      seed_q      <= seed_d;
      lfsr        <= lfsr_d;
      alt         <= alt_d;
      win_prev    <= win_prev_d;
      lose_prev   <= lose_prev_d;
      CTRL        <= ctrl_d;
      INIT        <= init_d;
      init_val    <= init_val_d;
      busy        <= busy_d;
      done        <= done_d;
      result      <= result_d;
      timeout     <= timeout_d;
      win_events  <= win_events_d;
      lose_events <= lose_events_d;
      moves       <= moves_d;
    end
  end

endmodule

// File: tb/tb_game_driver.sv
// Scoreboard bench for game_driver: a reference model predicts every PLAY-cycle
// output and the end-of-game record; a monitor pops and compares them.
module tb_game_driver;

  localparam int WIDTH = 3;
  localparam int MAXM  = 255;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       strategy;
  logic [WIDTH-1:0] seed;
  logic [1:0]       CTRL;
  logic             INIT;
  logic [WIDTH-1:0] init_val;
  logic             WINNER, LOSER, GAMEOVER;
  logic [1:0]       WHO;
  logic             busy, done, timeout;
  logic [1:0]       result;
  logic [3:0]       win_events, lose_events;
  logic [7:0]       moves;

  int checks = 0;
  int errors = 0;

  // Directly driven game inputs (random mode) and a behavioural game (game mode)
  logic       use_game;
  logic       d_w, d_l, d_go;
  logic [1:0] d_who;
  logic       g_win, g_lose, g_go;
  logic [1:0] g_who;
  logic [2:0] g_cnt;
  logic       g_armed, g_pw, g_pl;
  logic [3:0] g_ws, g_ls;

  bit r_w [1:MAXM];
  bit r_l [1:MAXM];
  int go_at;
  int r_who;

  typedef struct { int ctrl; int mv; int we; int le; } step_t;
  typedef struct { int res; int to; int we; int le; int mv; } end_t;
  step_t q_step[$];
  end_t  q_end[$];
  int    q_init[$];

  assign WINNER   = use_game ? g_win  : d_w;
  assign LOSER    = use_game ? g_lose : d_l;
  assign GAMEOVER = use_game ? g_go   : d_go;
  assign WHO      = use_game ? g_who  : d_who;

  game_driver #(.WIDTH(WIDTH), .MAX_MOVES(MAXM)) dut (
    .clk(clk), .rst(rst), .start(start), .strategy(strategy), .seed(seed),
    .CTRL(CTRL), .INIT(INIT), .init_val(init_val),
    .WINNER(WINNER), .LOSER(LOSER), .GAMEOVER(GAMEOVER), .WHO(WHO),
    .busy(busy), .done(done), .result(result), .timeout(timeout),
    .win_events(win_events), .lose_events(lose_events), .moves(moves)
  );

  always #5 clk = ~clk;

  function automatic int step_cnt(input int c, input int m);
    int add;
    case (m)
      0: add = 1;
      1: add = 2;
      2: add = 7;
      default: add = 6;
    endcase
    return (c + add) % 8;
  endfunction

  // Simple 3-bit game: scores on counter reaching all-ones / zero, ends at 15
  assign g_win  = g_armed && (g_cnt == 3'd7);
  assign g_lose = g_armed && (g_cnt == 3'd0);
  assign g_go   = g_armed && ((g_ws == 4'd15) || (g_ls == 4'd15));
  assign g_who  = (g_ws == 4'd15) ? 2'b10 : ((g_ls == 4'd15) ? 2'b01 : 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_cnt <= 3'd3; g_armed <= 1'b0; g_ws <= '0; g_ls <= '0; g_pw <= 1'b0; g_pl <= 1'b0;
    end else if (INIT) begin
      g_cnt <= init_val; g_armed <= 1'b1; g_ws <= '0; g_ls <= '0; g_pw <= 1'b0; g_pl <= 1'b0;
    end else if (!busy) begin
      g_armed <= 1'b0;
    end else if (g_armed) begin
      g_cnt <= 3'(step_cnt(int'(g_cnt), int'(CTRL)));
      g_pw  <= g_win;
      g_pl  <= g_lose;
      if (!g_go) begin
        if (g_win && !g_pw)   g_ws <= g_ws + 4'd1;
        if (g_lose && !g_pl)  g_ls <= g_ls + 4'd1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: walks the game move by move from the rules of play
  task automatic build_expect(input int st, input int sd, input bit gm, output int kend);
    int lf, fb, c, prev_c, cnt, ws, ls, gpw, gpl, we, le, pw, pl;
    int w, l, go, who;
    step_t s;
    end_t  e;
    lf = (160 + (sd % 32)) % 256;
    cnt = 0; ws = 0; ls = 0; gpw = 0; gpl = 0; we = 0; le = 0; pw = 0; pl = 0; prev_c = 0;
    kend = MAXM;
    q_init.push_back(sd);
    for (int k = 1; k <= MAXM; k++) begin
      if (gm) begin
        if (k == 1) begin
          w = 0; l = 0; go = 0; who = 0;
        end else begin
          w = (cnt == 7); l = (cnt == 0);
          go = (ws == 15 || ls == 15);
          who = (ws == 15) ? 2 : ((ls == 15) ? 1 : 0);
        end
      end else begin
        w = r_w[k]; l = r_l[k]; go = (k == go_at); who = r_who;
      end
      case (st)
        0: c = 0;
        1: c = 2;
        2: c = (k % 2 == 1) ? 1 : 2;
        default: c = lf % 4;
      endcase
      fb = ((lf / 128) + (lf / 32) + (lf / 16) + (lf / 8)) % 2;
      lf = (lf * 2 + fb) % 256;
      if (w && !pw && we < 15) we++;
      if (l && !pl && le < 15) le++;
      pw = w; pl = l;
      if (gm) begin
        if (k == 1) cnt = sd;
        else begin
          if (!go) begin
            if (w && !gpw) ws++;
            if (l && !gpl) ls++;
          end
          gpw = w; gpl = l;
          cnt = step_cnt(cnt, prev_c);
        end
      end
      prev_c = c;
      s.ctrl = c; s.mv = k; s.we = we; s.le = le;
      q_step.push_back(s);
      if (go) begin
        e.res = who; e.to = 0; e.we = we; e.le = le; e.mv = k; kend = k; break;
      end else if (k == MAXM) begin
        e.res = 0; e.to = 1; e.we = we; e.le = le; e.mv = k; kend = k;
      end
    end
    q_end.push_back(e);
  endtask

  // Monitor: samples just after each active edge and scores against the queues
  initial begin
    bit in_game = 0;
    step_t s;
    end_t  e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        in_game = 0;
      end else if (INIT) begin
        if (q_init.size() == 0) chk("init_unexpected", 1, 0);
        else chk("init_val", int'(init_val), q_init.pop_front());
        chk("busy_in_load", int'(busy), 1);
        in_game = 1;
      end else if (in_game) begin
        if (done) begin
          chk("steps_left_at_done", q_step.size(), 0);
          q_step.delete();
          if (q_end.size() == 0) chk("end_unexpected", 1, 0);
          else begin
            e = q_end.pop_front();
            chk("result", int'(result), e.res);
            chk("timeout", int'(timeout), e.to);
            chk("end_win_events", int'(win_events), e.we);
            chk("end_lose_events", int'(lose_events), e.le);
            chk("end_moves", int'(moves), e.mv);
            chk("ctrl_in_done", int'(CTRL), 0);
          end
          in_game = 0;
        end else if (q_step.size() == 0) begin
          chk("done_late", 0, 1);
          in_game = 0;
        end else begin
          s = q_step.pop_front();
          chk("ctrl", int'(CTRL), s.ctrl);
          chk("moves", int'(moves), s.mv);
          chk("win_events", int'(win_events), s.we);
          chk("lose_events", int'(lose_events), s.le);
        end
      end
    end
  end

  task automatic clear_inputs();
    for (int k = 1; k <= MAXM; k++) begin
      r_w[k] = 0; r_l[k] = 0;
    end
    go_at = 0; r_who = 0;
  endtask

  task automatic run_game(input int st, input int sd, input bit gm);
    int kend;
    bit seen;
    use_game = gm;
    build_expect(st, sd, gm, kend);
    @(negedge clk);
    start = 1'b1; strategy = 2'(st); seed = 3'(sd);
    @(negedge clk);
    start = 1'b0; strategy = 2'($urandom_range(0, 3)); seed = 3'($urandom_range(0, 7));
    for (int k = 1; k <= kend; k++) begin
      @(negedge clk);
      if (!gm) begin
        d_w = r_w[k]; d_l = r_l[k]; d_go = (k == go_at); d_who = 2'(r_who);
      end
      start = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    d_w = 1'b0; d_l = 1'b0; d_go = 1'b0; d_who = 2'b00; start = 1'b0;
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (done) seen = 1;
      else @(negedge clk);
    end
    chk("done_seen", int'(seen), 1);
    @(negedge clk);
  endtask

  initial begin
    int kend, sd;
    bit seen;
    rst = 1'b1; start = 1'b0; strategy = 2'b00; seed = '0; use_game = 1'b0;
    d_w = 1'b0; d_l = 1'b0; d_go = 1'b0; d_who = 2'b00;
    clear_inputs();
    @(negedge clk);
    chk("rst_ctrl", int'(CTRL), 0);
    chk("rst_init", int'(INIT), 0);
    chk("rst_init_val", int'(init_val), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_events", int'({win_events, lose_events}), 0);
    chk("rst_moves", int'(moves), 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a strategy-0 game
    build_expect(0, 4, 0, kend);
    @(negedge clk); start = 1'b1; strategy = 2'd0; seed = 3'd4;
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (moves == 8'd5) seen = 1;
    end
    chk("reached_move5", int'(seen), 1);
    rst = 1'b1;
    #1;
    chk("midrst_ctrl", int'(CTRL), 0);
    chk("midrst_init", int'(INIT), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_moves", int'(moves), 0);
    q_step.delete(); q_end.delete(); q_init.delete();
    @(negedge clk);
    rst = 1'b0;

    // Against the behavioural game
    run_game(0, 5, 1);
    run_game(0, 1, 1);
    chk("game_result_winner", int'(result), 2);
    chk("game_win_events", int'(win_events), 15);
    chk("game_no_timeout", int'(timeout), 0);

    // Strategy 2 to timeout, then strategy 3 ending on GAMEOVER at move 40
    clear_inputs();
    run_game(2, 0, 0);
    chk("timeout_moves", int'(moves), MAXM);
    go_at = 40; r_who = 2;
    run_game(3, 3, 0);
    chk("go40_moves", int'(moves), 40);
    go_at = MAXM; r_who = 1;
    run_game(1, 6, 0);

    // Randomized games
    for (int g = 0; g < 12; g++) begin
      for (int k = 1; k <= MAXM; k++) begin
        r_w[k] = ($urandom_range(0, 2) == 0);
        r_l[k] = ($urandom_range(0, 2) == 0);
      end
      go_at = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 120);
      r_who = $urandom_range(0, 2);
      sd = $urandom_range(0, 7);
      run_game($urandom_range(0, 3), sd, 0);
    end

    repeat (3) @(negedge clk);
    chk("queues_drained", q_step.size() + q_end.size() + q_init.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
